// File: rtl/zigzag_decryption_multikey.sv
// Zig-zag (rail-fence) decryption engine with a run-time rail count.
// A token-terminated ciphertext message is buffered and indexed by rail.
// The engine then emits the plaintext one character per cycle.
// Keys 0/1 and keys above MAX_KEY decrypt as identity. Keys above MAX_KEY
// and truncated messages raise err_o while the message is replayed.
module zigzag_decryption_multikey #(
  parameter int unsigned         D_WIDTH                = 8,
  parameter int unsigned         KEY_WIDTH              = 8,
  parameter int unsigned         MAX_NOF_CHARS          = 50,
  parameter int unsigned         MAX_KEY                = 8,
  parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 err_o
);

  localparam int unsigned CW = $clog2(MAX_NOF_CHARS + 1);               // counts 0..MAX_NOF_CHARS
  localparam int unsigned AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int unsigned PW = $clog2(2 * MAX_KEY);                      // phase and key
  localparam int unsigned RW = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;      // rail index

  typedef enum logic [1:0] {S_LOAD, S_SETUP, S_EMIT} state_e;

  // Rail of a phase value: rising leg 0..K-1, falling leg back toward 1.
  // Any k below 2 marks an identity message, where everything sits on rail 0.
  function automatic logic [PW-1:0] row_of(input logic [PW-1:0] p, input logic [PW-1:0] k);
    logic [PW-1:0] period;
    period = (k << 1) - PW'(2);
    if (k < PW'(2)) return '0;
    return (p < k) ? p : period - p;
  endfunction

  // Phase advance with a compare-and-clear wrap at P-1 instead of a modulo.
  function automatic logic [PW-1:0] phase_next(input logic [PW-1:0] p, input logic [PW-1:0] k);
    if (k < PW'(2)) return '0;
    return (p == (k << 1) - PW'(3)) ? '0 : p + PW'(1);
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     n_q, n_d;          // characters stored
  logic [CW-1:0]     out_q, out_d;      // characters emitted
  logic [CW-1:0]     acc_q, acc_d;      // running prefix sum during SETUP
  logic [RW-1:0]     cnt_q, cnt_d;      // SETUP step
  logic [PW-1:0]     phase_q, phase_d;
  logic [PW-1:0]     k_q, k_d;          // effective rail count, 0/1 = identity
  logic              kerr_q, kerr_d;    // sampled key was above MAX_KEY
  logic              trunc_q, trunc_d;
  logic [CW-1:0]     row_len_q [MAX_KEY];
  logic [CW-1:0]     row_len_d [MAX_KEY];
  logic [CW-1:0]     row_ptr_q [MAX_KEY];
  logic [CW-1:0]     row_ptr_d [MAX_KEY];
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic [D_WIDTH-1:0] mem_q [MAX_NOF_CHARS];

  logic              wr_en;
  logic              emit;
  logic              finish;
  logic [PW-1:0]     row;
  logic [RW-1:0]     row_idx;
  logic [CW-1:0]     rd_ptr;
  logic [PW-1:0]     key_k;
  logic              key_oor;
  logic [PW-1:0]     cur_k;
  logic              cur_kerr;

  // Key port decoded into an effective rail count plus the out-of-range flag.
  always_comb begin
    key_oor = (key > KEY_WIDTH'(MAX_KEY));
    key_k   = (key_oor || key < KEY_WIDTH'(2)) ? PW'(1) : PW'(key);
  end

  // Next-state logic for loading, prefix-sum setup and plaintext replay.
  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    out_d     = out_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    k_d       = k_q;
    kerr_d    = kerr_q;
    trunc_d   = trunc_q;
    row_len_d = row_len_q;
    row_ptr_d = row_ptr_q;
    busy_d    = busy_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    data_d    = '0;
    wr_en     = 1'b0;
    emit      = 1'b0;
    finish    = 1'b0;
    row       = '0;
    row_idx   = '0;
    rd_ptr    = '0;
    cur_k     = k_q;
    cur_kerr  = kerr_q;

    unique case (state_q)
      S_LOAD: begin
        // The first accepted character (or a bare token) fixes the key.
        if (n_q == '0) begin
          cur_k    = key_k;
          cur_kerr = key_oor;
        end
        if (valid_i) begin
          k_d    = cur_k;
          kerr_d = cur_kerr;
          if (data_i == START_DECRYPTION_TOKEN) begin
            state_d = S_SETUP;
            busy_d  = 1'b1;
            err_d   = trunc_q | cur_kerr;
            cnt_d   = '0;
            acc_d   = '0;
            phase_d = '0;
            out_d   = '0;
          end else if (n_q == CW'(MAX_NOF_CHARS)) begin
            trunc_d = 1'b1;
          end else begin
            wr_en              = 1'b1;
            row                = row_of(phase_q, cur_k);
            row_idx            = row[RW-1:0];
            row_len_d[row_idx] = row_len_q[row_idx] + CW'(1);
            phase_d            = phase_next(phase_q, cur_k);
            n_d                = n_q + CW'(1);
          end
        end
      end
      S_SETUP: begin
        // One rail per cycle: start pointer = sum of all shorter-index rails.
        row_ptr_d[cnt_q] = acc_q;
        acc_d            = acc_q + row_len_q[cnt_q];
        cnt_d            = cnt_q + RW'(1);
        if (cnt_q == RW'(MAX_KEY - 1)) begin
          // Rail 0 always starts at 0, so the first character can leave now.
          if (n_q == '0) begin
            finish = 1'b1;
          end else begin
            emit    = 1'b1;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_q == n_q) finish = 1'b1;
        else              emit   = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase

    if (emit) begin
      row                = row_of(phase_q, k_q);
      row_idx            = row[RW-1:0];
      rd_ptr             = row_ptr_q[row_idx];
      data_d             = mem_q[rd_ptr[AW-1:0]];
      valid_d            = 1'b1;
      row_ptr_d[row_idx] = rd_ptr + CW'(1);
      phase_d            = phase_next(phase_q, k_q);
      out_d              = out_q + CW'(1);
    end

    if (finish) begin
      state_d   = S_LOAD;
      busy_d    = 1'b0;
      err_d     = 1'b0;
      n_d       = '0;
      out_d     = '0;
      phase_d   = '0;
      k_d       = '0;
      kerr_d    = 1'b0;
      trunc_d   = 1'b0;
      row_len_d = '{default: '0};
      row_ptr_d = '{default: '0};
    end
  end

  // Control and output registers with synchronous reset.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      n_q       <= '0;
      out_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      phase_q   <= '0;
      k_q       <= '0;
      kerr_q    <= 1'b0;
      trunc_q   <= 1'b0;
      row_len_q <= '{default: '0};
      row_ptr_q <= '{default: '0};
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      out_q     <= out_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      k_q       <= k_d;
      kerr_q    <= kerr_d;
      trunc_q   <= trunc_d;
      row_len_q <= row_len_d;
      row_ptr_q <= row_ptr_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  // Ciphertext buffer, written in arrival order.
  // NOTE: the buffer has no reset; only locations below n_q are ever read, so stale data is harmless.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[n_q[AW-1:0]] <= data_i;
  end

  assign busy    = busy_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_zigzag_decryption_multikey.sv
// Self-checking bench for zigzag_decryption_multikey: directed vectors plus
// random messages, compared cycle by cycle against a rail-fence reference model.
module tb_zigzag_decryption_multikey;

  localparam int         D_WIDTH       = 8;
  localparam int         KEY_WIDTH     = 8;
  localparam int         MAX_NOF_CHARS = 50;
  localparam int         MAX_KEY       = 8;
  localparam logic [7:0] TOKEN         = 8'hFA;

  typedef logic [7:0] byte_q_t [$];

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] data_i  = '0;
  logic       valid_i = 1'b0;
  logic [7:0] key     = '0;
  logic       busy;
  logic       valid_o;
  logic       err_o;
  logic [7:0] data_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  zigzag_decryption_multikey #(
    .D_WIDTH(D_WIDTH), .KEY_WIDTH(KEY_WIDTH), .MAX_NOF_CHARS(MAX_NOF_CHARS),
    .MAX_KEY(MAX_KEY), .START_DECRYPTION_TOKEN(TOKEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .key(key),
    .busy(busy), .data_o(data_o), .valid_o(valid_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic byte_q_t str2q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Classic rail-fence decryption: trace the zig-zag, then deal the
  // ciphertext out rail by rail onto the positions each rail owns.
  function automatic byte_q_t zigzag_plain(input byte_q_t ct, input int k);
    byte_q_t pt;
    int      rails[$];
    int      n, r, dir, idx;
    n = (ct.size() > MAX_NOF_CHARS) ? MAX_NOF_CHARS : ct.size();
    for (int i = 0; i < n; i++) pt.push_back(ct[i]);
    if (k < 2 || k > MAX_KEY) return pt;
    r = 0;
    dir = 1;
    for (int i = 0; i < n; i++) begin
      rails.push_back(r);
      if (r == 0) dir = 1;
      else if (r == k - 1) dir = -1;
      r += dir;
    end
    idx = 0;
    for (int rr = 0; rr < k; rr++)
      for (int i = 0; i < n; i++)
        if (rails[i] == rr) begin
          pt[i] = ct[idx];
          idx++;
        end
    return pt;
  endfunction

  // Drives the message then the token; returns at the falling edge after the token edge.
  task automatic send_msg(input logic [7:0] k, input byte_q_t msg, input bit gaps);
    key = k;
    foreach (msg[i]) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          valid_i = 1'b0;
          data_i  = 8'($urandom);
          @(negedge clk);
        end
      end
      valid_i = 1'b1;
      data_i  = msg[i];
      @(negedge clk);
      if (gaps) key = 8'($urandom);  // must be ignored after the first character
    end
    valid_i = 1'b1;
    data_i  = TOKEN;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Cycle c counts falling edges after the token edge: busy for c = 1..MAX_KEY+n,
  // valid for c = MAX_KEY+1..MAX_KEY+n, idle at c = MAX_KEY+n+1.
  task automatic watch_msg(input byte_q_t exp_pt, input bit exp_err, input bit noise);
    int         n;
    bit         busy_e, val_e;
    logic [7:0] dat_e;
    n = exp_pt.size();
    for (int c = 1; c <= MAX_KEY + n + 1; c++) begin
      busy_e = (c <= MAX_KEY + n);
      val_e  = busy_e && (c > MAX_KEY);
      dat_e  = '0;
      if (val_e) dat_e = exp_pt[c - MAX_KEY - 1];
      check("busy", 32'(busy), 32'(busy_e));
      check("valid_o", 32'(valid_o), 32'(val_e));
      check("data_o", 32'(data_o), 32'(dat_e));
      check("err_o", 32'(err_o), 32'(busy_e && exp_err));
      if (busy_e) begin
        if (noise) begin
          valid_i = 1'($urandom_range(1));
          data_i  = ($urandom_range(7) == 0) ? TOKEN : 8'($urandom);
        end
        @(negedge clk);
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic run_msg(input logic [7:0] k, input byte_q_t msg, input bit gaps, input bit noise);
    byte_q_t exp_pt;
    bit      exp_err;
    exp_pt  = zigzag_plain(msg, int'(k));
    exp_err = (msg.size() > MAX_NOF_CHARS) || (k > MAX_KEY);
    send_msg(k, msg, gaps);
    watch_msg(exp_pt, exp_err, noise);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t    msg;
    logic [7:0] b;
    logic [7:0] k_r;
    int         len;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_err", 32'(err_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Classic key-3 vector
    run_msg(8'd3, str2q("WECRLTEERDSOEEFEAOCAIVDEN"), 1'b0, 1'b0);
    // Key 2, then back-to-back K >= N identity
    run_msg(8'd2, str2q("HLOEL"), 1'b0, 1'b0);
    run_msg(8'd8, str2q("ABC"), 1'b0, 1'b0);
    // Degenerate and out-of-range keys
    run_msg(8'd1, str2q("XYZ"), 1'b0, 1'b0);
    run_msg(8'd9, str2q("XYZ"), 1'b0, 1'b0);
    run_msg(8'd0, str2q("QRS"), 1'b0, 1'b0);
    // Overflow: 52 characters, only 50 kept
    msg.delete();
    for (int i = 1; i <= 52; i++) msg.push_back(8'(i));
    run_msg(8'd2, msg, 1'b0, 1'b0);
    // Empty message, and noisy inputs while busy
    msg.delete();
    run_msg(8'd3, msg, 1'b0, 1'b1);
    run_msg(8'd4, str2q("TESTINGNOISEWHILEBUSY"), 1'b0, 1'b1);

    // Random messages with gaps, key changes mid-message and busy-time noise
    for (int t = 0; t < 10; t++) begin
      msg.delete();
      len = $urandom_range(0, 24);
      k_r = 8'($urandom_range(0, 10));
      for (int i = 0; i < len; i++) begin
        do b = 8'($urandom); while (b == TOKEN);
        msg.push_back(b);
      end
      run_msg(k_r, msg, 1'b1, 1'b1);
    end

    // Reset in the middle of EMIT
    send_msg(8'd3, str2q("WECRLTEERDSOEEFEAOCAIVDEN"), 1'b0);
    repeat (MAX_KEY + 2) @(negedge clk);
    check("mid_valid", 32'(valid_o), 1);
    check("mid_data", 32'(data_o), 32'("A"));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(valid_o), 0);
    check("abort_data", 32'(data_o), 0);
    check("abort_err", 32'(err_o), 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("abort_quiet_valid", 32'(valid_o), 0);
      check("abort_quiet_busy", 32'(busy), 0);
    end
    run_msg(8'd2, str2q("HLOEL"), 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zigzag_decryption_multikey.md
# zigzag_decryption_multikey

Parametrised zig-zag (rail-fence) decryption engine, the successor of the fixed-key zig-zag decryptor in the cipher datapath. It buffers a ciphertext message terminated by a token character. It then replays the decrypted plaintext one character per cycle. Key range, character width, buffer depth and token value are parameters. It adds identity handling for degenerate keys and an error flag for truncated messages and out-of-range keys.

## Interface
- D_WIDTH, 8, character width in bits
- KEY_WIDTH, 8, key port width
- MAX_NOF_CHARS, 50, message buffer depth in characters
- MAX_KEY, 8, largest supported rail count (must be ≥2)
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message character (D_WIDTH bits)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- data_i  in  D_WIDTH  ciphertext character
- valid_i  in  1  data_i qualifier
- key  in  KEY_WIDTH  rail count K
- busy  out  1  high while decrypting; input ignored
- data_o  out  D_WIDTH  plaintext character, 0 when valid_o=0
- valid_o  out  1  data_o qualifier
- err_o  out  1  message truncated or key out of range; level, valid while busy

## Operation
- States: LOAD, SETUP, EMIT.
- **LOAD** (busy=0)
  - Each cycle with valid_i=1 and data_i≠token stores data_i at index N, then N++.
  - Key is sampled on the first accepted character of a message (or on the token if N=0). Later key changes within the message are ignored.
  - Row of index i: p = i mod P with P=2(K−1); row = p<K ? p : P−p. The per-row length counter row_len[row] is incremented.
  - Phase counter p wraps at P−1→0; no divider.
- **Overflow**: characters arriving when N=MAX_NOF_CHARS are dropped and a sticky trunc flag is set. The token is never stored.
- **Token accepted** (valid_i=1, data_i=token) → SETUP.
- **SETUP**: exactly MAX_KEY cycles regardless of K.
  - Computes row_ptr[r] = Σ row_len[0..r−1] for r<K.
  - Resets the output index and phase counter.
- **EMIT**: for j=0..N−1 on consecutive cycles:
  - row(j) is derived by the same phase counter.
  - data_o = buf[row_ptr[row(j)]], then row_ptr[row(j)]++.
  - valid_o=1.
- **After the last character**: return to LOAD; N, row_len, trunc and key are cleared.
- **Key 0 or 1**: identity; output equals stored ciphertext order.
- **Key > MAX_KEY**: identity output, err_o=1.
- **K ≥ N**: the algorithm naturally yields identity; no special case and no error.
- **err_o** = trunc | key_out_of_range. Driven from the token cycle's next edge until busy falls; 0 otherwise.
- **Arithmetic**: index, length and pointer counters are $clog2(MAX_NOF_CHARS+1) bits; phase counter is $clog2(2·MAX_KEY) bits; no wrap beyond MAX_NOF_CHARS is reachable.

## Timing
- **Reset** (rst_n=0 at an edge): next cycle busy=0, valid_o=0, data_o=0, err_o=0, state LOAD, N=0, row_len/row_ptr=0. Buffer contents are don't-care.
- Reset mid-LOAD/SETUP/EMIT aborts the message; no further valid_o.
- Let T0 be the edge sampling the token.
  - busy=1 from T0+1 through the cycle of the last valid_o.
  - First valid_o at cycle T0+1+MAX_KEY.
  - Last valid_o at T0+MAX_KEY+N.
  - busy=0 and valid_o=0 in the following cycle, which accepts a new character (back-to-back messages allowed).
- **Empty message** (N=0): busy high for MAX_KEY cycles, no valid_o.
- valid_i while busy=1 (including a token) is ignored: nothing stored, no error.
- Characters in the same cycle as rst_n=0 are discarded.

## Test plan
- **Key 3**, defaults: "WECRLTEERDSOEEFEAOCAIVDEN" + 0xFA.
  - Output "WEAREDISCOVEREDFLEEATONCE", 25 consecutive valid_o.
  - First valid_o at T0+9; busy falls after T0+33; err_o=0.
- **Key 2**: "HLOEL"+0xFA → "HELLO".
  - Then immediately key 8, "ABC"+0xFA → "ABC" (K≥N identity).
  - Check back-to-back acceptance the cycle busy falls.
- **Key 1, then key 9** (MAX_KEY=8): "XYZ"+0xFA → "XYZ".
  - err_o=0 for key 1; err_o=1 for key 9 throughout busy.
- **Overflow**: key 2, 52 characters 0x01..0x34 + token.
  - Exactly 50 outputs, the decryption of 0x01..0x32; err_o=1.
- **Busy/idle corner cases**:
  - Empty message: a bare 0xFA gives busy high for 8 cycles, no valid_o.
  - valid_i toggling with random data during busy does not alter output.
- **Reset mid-operation**: rst_n=0 for one cycle during EMIT of message 1.
  - Next cycle busy=valid_o=data_o=err_o=0.
  - A fresh "HLOEL" (key 2) then decrypts to "HELLO".
